// File: rtl/pattern_scan_ctrl.sv
`timescale 1ns/1ps
// pattern_scan_ctrl
// Frame-level serial pattern detector. Bytes arrive over a valid/ready
// stream, are shifted out MSB first one bit per clock, and a programmable
// length pattern (1..PW bits) is matched against the running bit history.
// History carries across byte boundaries, so matches may span bytes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; match_count holds last frame's result
// LOAD  | in_ready high, waiting for the next byte of the frame
// SHIFT | serialising the captured byte, one bit per clock (DW cycles)
// DONE  | one-cycle end-of-frame pulse, then back to IDLE
module pattern_scan_ctrl #(
  parameter int DW = 8,
  parameter int PW = 8,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PW-1:0]         cfg_pattern,
  input  logic [$clog2(PW):0]   cfg_len,
  input  logic                  cfg_overlap,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  match,
  output logic [CW-1:0]         match_pos,
  output logic [CW-1:0]         match_count,
  output logic                  done
);

  localparam int LW  = $clog2(PW) + 1;
  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [LW-1:0]  PW_L    = LW'(PW);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // latched frame configuration
  logic [PW-1:0]  pat_q;
  logic [LW-1:0]  len_q;
  logic           ovl_q;

  // serialiser
  logic [DW-1:0]  sh_buf;
  logic           last_q;
  logic [BCW-1:0] bit_cnt;

  // detector
  logic [PW-1:0]  hist;
  logic [LW-1:0]  bits_seen;
  logic [CW-1:0]  bit_idx;

  logic [PW-1:0]  hist_new;
  logic [PW-1:0]  len_mask;
  logic [LW-1:0]  seen_inc;
  logic [LW:0]    seen_p1;
  logic           len_ok;
  logic           hit;

  // Detector comparison against the history as it will look after this bit.
  always_comb begin
    hist_new = {hist[PW-2:0], sh_buf[DW-1]};
    seen_inc = (bits_seen == PW_L) ? bits_seen : bits_seen + LW'(1);
    seen_p1  = {1'b0, bits_seen} + (LW+1)'(1);
    len_ok   = (len_q != '0) && (len_q <= PW_L);
    len_mask = '0;
    for (int i = 0; i < PW; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = (state == S_SHIFT) && len_ok &&
          (seen_p1 >= {1'b0, len_q}) &&
          ((hist_new & len_mask) == (pat_q & len_mask));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (bit_cnt == '0) state_nxt = last_q ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config latch, serialiser, history and match reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      sh_buf      <= '0;
      last_q      <= 1'b0;
      bit_cnt     <= '0;
      hist        <= '0;
      bits_seen   <= '0;
      bit_idx     <= '0;
      match       <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
    end else begin
      match <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            ovl_q       <= cfg_overlap;
            hist        <= '0;
            bits_seen   <= '0;
            bit_idx     <= '0;
            match_count <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            sh_buf  <= in_data;
            last_q  <= in_last;
            bit_cnt <= BC_LAST;
          end
        end
        S_SHIFT: begin
          sh_buf  <= {sh_buf[DW-2:0], 1'b0};
          bit_cnt <= bit_cnt - BCW'(1);
          hist    <= hist_new;
          bit_idx <= bit_idx + CW'(1);
          if (hit) begin
            match     <= 1'b1;
            match_pos <= bit_idx;
            if (match_count != {CW{1'b1}}) begin
              match_count <= match_count + CW'(1);
            end
            // non-overlap mode consumes the matched bits
            bits_seen <= ovl_q ? seen_inc : '0;
          end else begin
            bits_seen <= seen_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
